// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared types and constants for the BRAM stream reader
//
// Purpose: FSM state encoding, output buffer depth and the transfer-length
// width helper shared by bram_stream_reader and stream_fifo2.
// Ports: none (package).
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 2;

  // One extra bit so a transfer can cover the whole RAM (2**addr_w words).
  function automatic int len_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - 2-entry first-word-fall-through FIFO with data+last payload
//
// Purpose: output buffer for the BRAM reader; the head entry drives the stream.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_data/last  write one entry (caller guarantees space)
//   pop                   remove head entry (caller guarantees non-empty)
//   head_data/last/valid  current head entry and whether it exists
//   count                 number of stored entries (0..2)
module stream_fifo2
  import bram_stream_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              head_valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_d [FIFO_DEPTH];
  logic              last_q [FIFO_DEPTH];
  logic              last_d [FIFO_DEPTH];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data  = data_q[rd_ptr_q];
  assign head_last  = last_q[rd_ptr_q];
  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == 2'd2)));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (cnt_q == 2'd0)));

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - BRAM read master producing a valid/ready pixel stream
//
// Purpose: reads len words starting at base_addr from a single-port BRAM with
// 1-cycle registered read latency and presents them as a stream with last flag.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, base_addr, len      transfer request (sampled in IDLE only)
//   busy, done                 transfer status; done pulses once at the end
//   mem_addr, mem_we, mem_dout RAM read port (never writes)
//   m_data, m_valid, m_last    output stream
//   m_ready                    downstream ready
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = len_width(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;            // next address to issue
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;  // held on mem_addr between issues
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic              pop;
  logic              issue;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occupancy;
  logic              head_last;

  assign pop = m_valid & m_ready;

  // Slots already claimed once this cycle's pop is accounted for; issuing is
  // only safe while a free slot will exist when the read data lands.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == READ) && (occupancy < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    last_addr_d     = last_addr_q;
    issue_cnt_d     = issue_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d     = READ;
            addr_d      = base_addr;
            issue_cnt_d = len;
            beat_cnt_d  = len;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d          = addr_q + ADDR_W'(1);
          last_addr_d     = addr_q;
          issue_cnt_d     = issue_cnt_q - LEN_W'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (issue_cnt_q == LEN_W'(1));
          if (issue_cnt_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt_q == LEN_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      beat_cnt_d = beat_cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      last_addr_q     <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      last_addr_q     <= last_addr_d;
      issue_cnt_q     <= issue_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // The in-flight word is on mem_dout this cycle; capture it straight away.
  stream_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (mem_dout),
    .push_last (inflight_last_q),
    .pop       (pop),
    .head_data (m_data),
    .head_last (head_last),
    .head_valid(m_valid),
    .count     (fifo_cnt)
  );

  // Stale head entries keep their last bit; only a valid head may signal it.
  assign m_last   = head_last & m_valid;
  assign mem_addr = issue ? addr_q : last_addr_q;
  assign mem_we   = 1'b0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - self-checking bench for bram_stream_reader
module tb_bram_stream_reader;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = 12;
  localparam int DEPTH  = 2048;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_last;
  logic              m_ready;

  bram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_dout(mem_dout), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) mem_dout <= ram[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected word list per transfer, plus busy/done status.
  typedef struct { logic [DATA_W-1:0] d; logic l; } beat_t;
  beat_t             exp_q[$];
  bit                mbusy, mdone, nbusy, last_hs, stall, stall_last;
  logic [DATA_W-1:0] stall_data;
  logic [DATA_W-1:0] last_beat;
  int                hs_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mbusy = 0;
      mdone = 0;
      stall = 0;
    end else begin
      chk("busy", 32'(busy), 32'(mbusy));
      chk("done", 32'(done), 32'(mdone));
      chk("mem_we", 32'(mem_we), 32'd0);
      last_hs = 0;
      if (m_valid) begin
        chk("valid_expected", 32'(m_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          if (stall) begin
            chk("hold_data", 32'(m_data), 32'(stall_data));
            chk("hold_last", 32'(m_last), 32'(stall_last));
          end
          chk("data", 32'(m_data), 32'(exp_q[0].d));
          chk("last", 32'(m_last), 32'(exp_q[0].l));
          if (m_ready) begin
            last_hs   = exp_q[0].l;
            last_beat = m_data;
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end else if (stall) begin
        chk("valid_held", 32'(m_valid), 32'd1);
      end
      stall      = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;

      nbusy = mbusy;
      if (!mbusy && start) begin
        nbusy = 1;
        for (int i = 0; i < int'(len); i++)
          exp_q.push_back('{d: ram[(int'(base_addr) + i) % DEPTH], l: (i == int'(len) - 1)});
      end
      if (mdone) nbusy = 0;
      mdone = last_hs || (!mbusy && start && (len == '0));
      mbusy = nbusy;
    end
  end

  // Ready pattern: 0 = always ready, 1 = fixed 1,0,0,1,0,1 cycle, 2 = random.
  int rmode = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = pat[k % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  task automatic start_xfer(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    len       = LEN_W'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("all_words_delivered", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc, h0;
    logic [ADDR_W-1:0] ma;
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, h0;
    logic [ADDR_W-1:0] ma;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'(a);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic transfer: first beat two cycles after start is sampled.
    rmode = 0;
    start_xfer(16'h010, 4);
    @(negedge clk);
    chk("t1_busy_next", 32'(busy), 32'd1);
    chk("t1_valid_n0", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n1", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n2", 32'(m_valid), 32'd1);
    chk("t1_first_data", 32'(m_data), 32'h10);
    wait_done(50, cyc);
    chk("t1_done_latency", 32'(cyc), 32'd4);
    chk("t1_last_word", 32'(last_beat), 32'h13);
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Address wrap at the top of the RAM.
    start_xfer(2046, 4);
    wait_done(50, cyc);
    chk("wrap_last_word", 32'(last_beat), 32'd1);

    // Backpressure pattern, with an ignored start mid-transfer.
    rmode = 1;
    h0 = hs_count;
    start_xfer(16'h020, 8);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 11'h100;
    len       = 12'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200, cyc);
    chk("bp_beats", 32'(hs_count - h0), 32'd8);
    chk("bp_last_word", 32'(last_beat), 32'h27);
    rmode = 0;

    // Zero-length transfer: no reads, done on the next cycle.
    repeat (2) @(posedge clk);
    ma = mem_addr;
    start_xfer(16'h300, 0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_valid", 32'(m_valid), 32'd0);
    chk("len0_addr", 32'(mem_addr), 32'(ma));
    @(negedge clk);
    chk("len0_done_after", 32'(done), 32'd0);
    chk("len0_busy_after", 32'(busy), 32'd0);
    chk("len0_addr_after", 32'(mem_addr), 32'(ma));

    // Reset after the third of ten beats.
    h0 = hs_count;
    start_xfer(16'h200, 10);
    cyc = 0;
    while (hs_count - h0 < 3 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    chk("rst_mid_reached", 32'(hs_count - h0 >= 3), 32'd1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    start_xfer(0, 2);
    wait_done(50, cyc);
    chk("post_rst_last", 32'(last_beat), 32'd1);

    // Randomized transfers over random RAM contents.
    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'($urandom);
    for (int n = 0; n < 14; n++) begin
      rmode = (n % 4 == 0) ? 0 : 2;
      start_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
      wait_done(400, cyc);
    end
    rmode = 2;
    h0 = hs_count;
    start_xfer(int'($urandom_range(0, DEPTH - 1)), DEPTH);
    wait_done(20000, cyc);
    chk("full_ram_beats", 32'(hs_count - h0), 32'(DEPTH));

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side master for the single-port block RAM: given a base address and a pixel count, it drives the RAM address and turns the registered read data into a valid/ready pixel stream with a last flag. It sits between a frame/line BRAM and the median-filter window logic. It accounts for the RAM's fixed 1-cycle read latency and absorbs downstream backpressure without dropping or duplicating words.

Parameters:
DATA_W, 24, pixel/word width (matches RAM data width)
ADDR_W, 11, RAM address width; RAM depth 2**ADDR_W
LEN_W, ADDR_W+1, width of transfer length; allows up to a full RAM (2**ADDR_W words)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
base_addr  in  ADDR_W  first RAM address, sampled with start
len  in  LEN_W  number of words to read, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final beat is accepted
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable; constant 0
mem_dout  in  DATA_W  RAM registered read data for the address presented on the previous cycle
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_last  out  1  marks final word of the transfer
m_ready  in  1  downstream ready

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE. busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_addr=0. Issue counter, beat counter, in-flight flag and buffer are all cleared. Reset mid-transfer aborts the transfer with no done pulse and discards buffered data.
- States:
  - IDLE: start=1 and len!=0 -> READ. Latch base_addr and len; busy=1 from the next cycle.
  - IDLE: start=1 and len=0 -> DONE. No beats; done pulses the following cycle.
  - READ: issues reads. When the last address has been issued -> DRAIN.
  - DRAIN: waits until the last beat is accepted (m_valid & m_ready & m_last) -> DONE.
  - DONE: done=1 for exactly one cycle; busy falls with done. -> IDLE.
  - start while not in IDLE is ignored.
- Read issue: a read is issued in cycle t by driving mem_addr=A. The word for A is captured from mem_dout in cycle t+1, tracked by a 1-bit in-flight flag.
  - Issue only when (buffer count + in-flight - pop this cycle) < 2, where pop = m_valid & m_ready.
  - Addresses increment by 1 per issue and wrap modulo 2**ADDR_W. Example: base 2046, len 4 reads 2046, 2047, 0, 1.
  - mem_addr holds its last value when not issuing; only the in-flight flag qualifies captured data.
- Buffer: 2-entry FIFO for output data.
  - m_data/m_valid come from the head entry.
  - A simultaneous capture and pop is legal and preserves order.
  - Neither overflow nor underflow is reachable under the issue rule; verification asserts this.
- Throughput: with m_ready held high, one beat per cycle after an initial 2-cycle latency (start at t0, first m_valid at t0+2, since the first read is issued at t0+1).
- Stream rules:
  - Once m_valid=1, m_data and m_last are stable until accepted.
  - m_valid never drops without a handshake.
  - m_last=1 only on beat number len.
- Counters: issue counter and beat counter are LEN_W bits and count down from len. len=2**ADDR_W is legal.
- mem_we is tied to 0. This block never writes the RAM.

Decomposition:
- Package bram_stream_pkg holds:
  - state enum: IDLE, READ, DRAIN, DONE
  - LEN_W derivation helper
  - FIFO_DEPTH=2 constant
- One sub-module, stream_fifo2: a 2-entry, first-word-fall-through FIFO with push/pop/count and a data+last payload. Top level keeps the FSM, address generation, in-flight tracking and credit check.

Test Plan:
- Reset, then start with base=0x010, len=4 and m_ready=1 (RAM preloaded word[a]=a) -> m_data 0x10..0x13 on consecutive cycles from t0+2; m_last on 0x13; done one cycle after; busy low after done.
- base=2046, len=4 -> addresses 2046, 2047, 0, 1 in that order; m_last on the word from address 1.
- len=8 with m_ready toggling 1,0,0,1,0,1... -> all 8 words delivered in order, no duplicates or drops; m_data stable while m_valid & !m_ready; FIFO overflow assertion never fires.
- len=0 -> no m_valid, no mem_addr change; done pulses one cycle after start; busy high for one cycle.
- start pulsed again mid-transfer with base=0x100 -> ignored; original stream completes unchanged.
- rst_n=0 after the 3rd of len=10 beats -> next cycle m_valid=0, busy=0, no done; a following start (base=0, len=2) runs cleanly.
